// File: rtl/instruction_fetch_if.sv
// Fetch-side bus bundle: program-memory req/ack handshake plus the opcode/value
// hand-off to the PC. The fetch unit is the master.
interface instruction_fetch_if #(
    parameter int OPCODE_WIDTH = 4,
    parameter int VALUE_WIDTH  = 8,
    parameter int PC_WIDTH     = 8
);
    logic [PC_WIDTH-1:0]                 pc;
    logic                                memReq;
    logic [PC_WIDTH-1:0]                 memAddr;
    logic                                memAck;
    logic [OPCODE_WIDTH+VALUE_WIDTH-1:0] memData;
    logic                                fetchValid;
    logic [OPCODE_WIDTH-1:0]             resetCode;
    logic [VALUE_WIDTH-1:0]              instructionValue;
    logic                                fault;

    modport master (
        input  pc, memAck, memData,
        output memReq, memAddr, fetchValid, resetCode, instructionValue, fault
    );

    modport slave (
        output pc, memAck, memData,
        input  memReq, memAddr, fetchValid, resetCode, instructionValue, fault
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer: boots the PC with RESET_CODE, then loops
// REQUEST -> WAIT -> EXEC, presenting each fetched opcode/value for one cycle.
module instruction_fetch #(
    parameter int                      OPCODE_WIDTH = 4,
    parameter int                      VALUE_WIDTH  = 8,
    parameter int                      PC_WIDTH     = 8,
    parameter logic [OPCODE_WIDTH-1:0] RESET_CODE   = OPCODE_WIDTH'(4'hF),
    parameter int                      TIMEOUT      = 16
) (
    input  logic                clock,
    input  logic                resetN,
    instruction_fetch_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        BOOT,
        REQUEST,
        WAIT,
        EXEC
    } state_e;

    state_e                  state_q;
    logic                    mem_req_q;
    logic [PC_WIDTH-1:0]     mem_addr_q;
    logic                    fetch_valid_q;
    logic [OPCODE_WIDTH-1:0] reset_code_q;
    logic [VALUE_WIDTH-1:0]  instr_value_q;
    logic                    fault_q;
    logic [CNT_W-1:0]        tmo_cnt_q;
    logic [CNT_W-1:0]        tmo_cnt_d;

    assign tmo_cnt_d = tmo_cnt_q + CNT_W'(1);

    // NOTE: every register below is assigned with <= so all of them sample the
    // pre-edge values; a blocking = here would leak same-cycle updates between them.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q       <= BOOT;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            fetch_valid_q <= 1'b0;
            reset_code_q  <= RESET_CODE;
            instr_value_q <= '0;
            fault_q       <= 1'b0;
            tmo_cnt_q     <= '0;
        end else begin
            case (state_q)
                BOOT: begin
                    fetch_valid_q <= 1'b1;
                    reset_code_q  <= RESET_CODE;
                    state_q       <= REQUEST;
                end
                REQUEST: begin
                    fetch_valid_q <= 1'b0;
                    mem_req_q     <= 1'b1;
                    mem_addr_q    <= bus.pc;
                    tmo_cnt_q     <= '0;
                    state_q       <= WAIT;
                end
                WAIT: begin
                    if (bus.memAck) begin
                        mem_req_q     <= 1'b0;
                        reset_code_q  <= bus.memData[OPCODE_WIDTH+VALUE_WIDTH-1 -: OPCODE_WIDTH];
                        instr_value_q <= bus.memData[VALUE_WIDTH-1:0];
                        fetch_valid_q <= 1'b1;
                        state_q       <= EXEC;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                        // Timeout acts like a fresh boot: PC reloads 0, then refetch.
                        if (tmo_cnt_d == CNT_W'(TIMEOUT)) begin
                            fault_q       <= 1'b1;
                            mem_req_q     <= 1'b0;
                            reset_code_q  <= RESET_CODE;
                            fetch_valid_q <= 1'b1;
                            state_q       <= REQUEST;
                        end
                    end
                end
                EXEC: begin
                    fetch_valid_q <= 1'b0;
                    state_q       <= REQUEST;
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    assign bus.memReq           = mem_req_q;
    assign bus.memAddr          = mem_addr_q;
    assign bus.fetchValid       = fetch_valid_q;
    assign bus.resetCode        = reset_code_q;
    assign bus.instructionValue = instr_value_q;
    assign bus.fault            = fault_q;
endmodule
